// File: rtl/unpooling_layer_stream.sv
// ============================================================================
// Module   : unpooling_layer_stream
// Brief    : Streaming row-buffered upsampler (nearest replicate / zero-insert)
// Revision : 1.0
// ============================================================================
`default_nettype none

module unpooling_layer_stream #(
    parameter int ELEM_WIDTH   = 8,
    parameter int MAX_IN_WIDTH = 32,
    parameter int MAX_SCALE    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            in_height,
    input  logic [7:0]            in_width,
    input  logic [7:0]            scale,
    input  logic [1:0]            mode,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [ELEM_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ELEM_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    localparam int c_AW = (MAX_IN_WIDTH > 1) ? $clog2(MAX_IN_WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EMIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [ELEM_WIDTH-1:0] r_line_buf [MAX_IN_WIDTH];

    logic [7:0] r_height;
    logic [7:0] r_width;
    logic [7:0] r_scale;
    logic       r_zero_ins;
    logic [7:0] r_row;
    logic [7:0] r_col;
    logic [7:0] r_sub_row;
    logic [7:0] r_out_col;
    logic [7:0] r_sub_col;
    logic       r_issue_done;

    logic                  r_m_valid;
    logic [ELEM_WIDTH-1:0] r_m_data;
    logic                  r_m_last;
    logic                  r_cfg_err;

    logic w_cfg_ok;
    logic w_start_ok;
    logic w_start_bad;
    logic w_in_hs;
    logic w_last_col;
    logic w_out_hs;
    logic w_load;
    logic w_row_end;
    logic w_last_row;
    logic w_sub_col_last;
    logic w_out_col_last;
    logic w_sub_row_last;
    logic w_issue_last;
    logic [ELEM_WIDTH-1:0] w_buf_rd;
    logic [ELEM_WIDTH-1:0] w_beat_data;

    assign w_cfg_ok = (scale != 8'd0) && (scale <= 8'(MAX_SCALE)) &&
                      (in_width != 8'd0) && (in_width <= 8'(MAX_IN_WIDTH)) &&
                      (in_height != 8'd0) && !mode[1];

    assign w_start_ok  = (r_state == S_IDLE) && start && w_cfg_ok;
    assign w_start_bad = (r_state == S_IDLE) && start && !w_cfg_ok;

    assign w_in_hs    = (r_state == S_LOAD) && s_valid;
    assign w_last_col = (r_col == r_width - 8'd1);

    // Issue counters run one beat ahead of the output register; a beat is
    // loaded whenever the register is empty or being drained this cycle.
    assign w_out_hs  = r_m_valid && m_ready;
    assign w_load    = (r_state == S_EMIT) && !r_issue_done && (!r_m_valid || m_ready);
    assign w_row_end = (r_state == S_EMIT) && r_issue_done && w_out_hs;

    assign w_last_row     = (r_row == r_height - 8'd1);
    assign w_sub_col_last = (r_sub_col == r_scale - 8'd1);
    assign w_out_col_last = (r_out_col == r_width - 8'd1);
    assign w_sub_row_last = (r_sub_row == r_scale - 8'd1);
    assign w_issue_last   = w_sub_row_last && w_out_col_last && w_sub_col_last;

    assign w_buf_rd    = r_line_buf[r_out_col[c_AW-1:0]];
    assign w_beat_data = (!r_zero_ins || ((r_sub_row == 8'd0) && (r_sub_col == 8'd0)))
                         ? w_buf_rd : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_start_ok) w_state_next = S_LOAD;
            S_LOAD: if (w_in_hs && w_last_col) w_state_next = S_EMIT;
            S_EMIT: if (w_row_end) w_state_next = w_last_row ? S_DONE : S_LOAD;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Line buffer holds data only; it needs no reset.
    always_ff @(posedge clk) begin
        if (w_in_hs) begin
            r_line_buf[r_col[c_AW-1:0]] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_height     <= 8'd0;
            r_width      <= 8'd0;
            r_scale      <= 8'd0;
            r_zero_ins   <= 1'b0;
            r_row        <= 8'd0;
            r_col        <= 8'd0;
            r_sub_row    <= 8'd0;
            r_out_col    <= 8'd0;
            r_sub_col    <= 8'd0;
            r_issue_done <= 1'b0;
            r_m_valid    <= 1'b0;
            r_m_data     <= '0;
            r_m_last     <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_cfg_err <= w_start_bad;

            if (w_start_ok) begin
                r_height   <= in_height;
                r_width    <= in_width;
                r_scale    <= scale;
                r_zero_ins <= mode[0];
                r_row      <= 8'd0;
                r_col      <= 8'd0;
            end

            if (w_in_hs) begin
                r_col <= w_last_col ? 8'd0 : r_col + 8'd1;
            end

            if (w_row_end) begin
                r_issue_done <= 1'b0;
                r_row        <= w_last_row ? 8'd0 : r_row + 8'd1;
            end

            if (w_load) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_beat_data;
                r_m_last  <= w_last_row && w_issue_last;
                // Nested counters wrap naturally back to zero after the last beat.
                if (w_sub_col_last) begin
                    r_sub_col <= 8'd0;
                    if (w_out_col_last) begin
                        r_out_col <= 8'd0;
                        r_sub_row <= w_sub_row_last ? 8'd0 : r_sub_row + 8'd1;
                    end else begin
                        r_out_col <= r_out_col + 8'd1;
                    end
                end else begin
                    r_sub_col <= r_sub_col + 8'd1;
                end
                if (w_issue_last) begin
                    r_issue_done <= 1'b1;
                end
            end else if (w_out_hs) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end
        end
    end

    assign s_ready = (r_state == S_LOAD);
    assign busy    = (r_state == S_LOAD) || (r_state == S_EMIT);
    assign done    = (r_state == S_DONE);
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_last  = r_m_last;
    assign cfg_err = r_cfg_err;

endmodule

`default_nettype wire

// File: tb/tb_unpooling_layer_stream.sv
// ============================================================================
// Module   : tb_unpooling_layer_stream
// Brief    : Directed self-checking bench for unpooling_layer_stream
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_unpooling_layer_stream;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] in_height;
    logic [7:0] in_width;
    logic [7:0] scale;
    logic [1:0] mode;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic       busy;
    logic       done;
    logic       cfg_err;

    int n_total = 0;
    int n_bad   = 0;

    int in_v  [0:127];
    int exp_v [0:127];

    int c_exp_nn [16] = '{1,1,2,2, 1,1,2,2, 3,3,4,4, 3,3,4,4};
    int c_exp_zi [16] = '{1,0,2,0, 0,0,0,0, 3,0,4,0, 0,0,0,0};
    int c_exp_s3 [27] = '{7,7,7,8,8,8,9,9,9, 7,7,7,8,8,8,9,9,9, 7,7,7,8,8,8,9,9,9};

    unpooling_layer_stream #(
        .ELEM_WIDTH  (8),
        .MAX_IN_WIDTH(32),
        .MAX_SCALE   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_height(in_height),
        .in_width (in_width),
        .scale    (scale),
        .mode     (mode),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .busy     (busy),
        .done     (done),
        .cfg_err  (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_start(input int h, input int w, input int s, input int m);
        in_height = 8'(h);
        in_width  = 8'(w);
        scale     = 8'(s);
        mode      = 2'(m);
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    // Feeds in_v, drains and checks against exp_v; abort_after>0 stops early.
    task automatic run_frame(input string name, input int n_in, input int n_out,
                             input int w, input bit toggle, input int abort_after);
        int  ii = 0, oo = 0, cyc = 0;
        int  lat_in = -1, first_v = -1;
        int  stall_bad = 0, overlap = 0, n_last = 0, last_idx = -1, n_done = 0;
        bit  rdy = 1'b1, stalled = 1'b0, hold_l = 1'b0, acc;
        logic [7:0] hold_d = '0;
        while (oo < n_out && cyc < 3000) begin
            s_valid = (ii < n_in);
            s_data  = (ii < n_in) ? 8'(in_v[ii]) : 8'd0;
            m_ready = rdy;
            @(negedge clk);
            acc = s_valid && s_ready;
            if (acc && (ii + 1 == w) && lat_in < 0) lat_in = cyc;
            if (m_valid && first_v < 0) first_v = cyc;
            if (m_valid && s_ready) overlap++;
            if (done) n_done++;
            if (stalled && m_valid && (m_data !== hold_d || m_last !== hold_l)) stall_bad++;
            stalled = m_valid && !m_ready;
            hold_d  = m_data;
            hold_l  = m_last;
            if (m_valid && m_ready) begin
                chk($sformatf("%s beat%0d", name, oo), 32'(m_data), 32'(exp_v[oo]));
                if (m_last) begin
                    n_last++;
                    last_idx = oo;
                end
                oo++;
            end
            @(posedge clk); #1;
            if (acc) ii++;
            if (toggle) rdy = !rdy;
            cyc++;
            if (abort_after > 0 && oo == abort_after) break;
        end
        s_valid = 1'b0;
        if (abort_after > 0) begin
            chk({name, " beats_before_abort"}, 32'(oo), 32'(abort_after));
        end else begin
            m_ready = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                if (done) n_done++;
            end
            chk({name, " beats"}, 32'(oo), 32'(n_out));
            chk({name, " inputs"}, 32'(ii), 32'(n_in));
            chk({name, " latency"}, 32'(first_v - lat_in), 32'd2);
            chk({name, " last_count"}, 32'(n_last), 32'd1);
            chk({name, " last_idx"}, 32'(last_idx), 32'(n_out - 1));
            chk({name, " done_count"}, 32'(n_done), 32'd1);
            chk({name, " stall_stable"}, 32'(stall_bad), 32'd0);
            chk({name, " load_emit_overlap"}, 32'(overlap), 32'd0);
            chk({name, " busy_after"}, 32'(busy), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, " s_ready"}, 32'(s_ready), 32'd0);
        chk({name, " m_valid"}, 32'(m_valid), 32'd0);
        chk({name, " m_data"},  32'(m_data),  32'd0);
        chk({name, " m_last"},  32'(m_last),  32'd0);
        chk({name, " busy"},    32'(busy),    32'd0);
        chk({name, " done"},    32'(done),    32'd0);
        chk({name, " cfg_err"}, 32'(cfg_err), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_height = '0; in_width = '0; scale = '0;
        mode = '0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // 2x2 nearest, scale 2
        for (int i = 0; i < 4; i++) in_v[i] = i + 1;
        for (int i = 0; i < 16; i++) exp_v[i] = c_exp_nn[i];
        do_start(2, 2, 2, 0);
        chk("nn busy_after_start", 32'(busy), 32'd1);
        run_frame("nn", 4, 16, 2, 1'b0, 0);

        // 2x2 zero-insert, scale 2
        for (int i = 0; i < 16; i++) exp_v[i] = c_exp_zi[i];
        do_start(2, 2, 2, 1);
        run_frame("zi", 4, 16, 2, 1'b0, 0);

        // 1x3 scale 3 with toggling backpressure
        in_v[0] = 7; in_v[1] = 8; in_v[2] = 9;
        for (int i = 0; i < 27; i++) exp_v[i] = c_exp_s3[i];
        do_start(1, 3, 3, 0);
        run_frame("bp", 3, 27, 3, 1'b1, 0);

        // rejected configurations
        do_start(2, 2, 5, 0);
        chk("scale5 cfg_err", 32'(cfg_err), 32'd1);
        chk("scale5 busy", 32'(busy), 32'd0);
        chk("scale5 s_ready", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        chk("scale5 cfg_err_pulse", 32'(cfg_err), 32'd0);
        do_start(2, 33, 2, 0);
        chk("width33 cfg_err", 32'(cfg_err), 32'd1);
        chk("width33 busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        do_start(2, 2, 2, 2);
        chk("mode2 cfg_err", 32'(cfg_err), 32'd1);
        chk("mode2 s_ready", 32'(s_ready), 32'd0);
        @(posedge clk); #1;

        // 4x32 ramp, scale 1 pass-through in zero-insert mode
        for (int i = 0; i < 128; i++) begin
            in_v[i]  = i;
            exp_v[i] = i;
        end
        do_start(4, 32, 1, 1);
        run_frame("ramp", 128, 128, 32, 1'b0, 0);

        // mid-frame reset, then a fresh frame
        for (int i = 0; i < 4; i++) in_v[i] = i + 1;
        for (int i = 0; i < 16; i++) exp_v[i] = c_exp_nn[i];
        do_start(2, 2, 2, 0);
        run_frame("abort", 4, 16, 2, 1'b0, 5);
        rst = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_start(2, 2, 2, 0);
        run_frame("after_rst", 4, 16, 2, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/unpooling_layer_stream.md
Name: unpooling_layer_stream

Overview:
Streaming upsampler that performs the inverse of the pooling layer. It accepts a pooled feature map one element per beat in raster order. It emits an enlarged map (in_height*scale x in_width*scale) in raster order, using either nearest-neighbour replication or zero-insert unpooling. It sits on the decoder/upsampling path and buffers one input row at a time in a line buffer.

Parameters:
ELEM_WIDTH, 8, bits per element
MAX_IN_WIDTH, 32, maximum input row length (line buffer depth)
MAX_SCALE, 4, maximum upsampling factor

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  frame start pulse; sampled only in IDLE
in_height  in  8  input rows
in_width  in  8  input columns
scale  in  8  upsampling factor, applied to both H and W
mode  in  2  0: nearest replicate, 1: zero-insert, 2/3: reserved
s_valid  in  1  input element valid
s_ready  out  1  block can accept an input element
s_data  in  ELEM_WIDTH  input element
m_valid  out  1  output element valid
m_ready  in  1  downstream accepts
m_data  out  ELEM_WIDTH  output element
m_last  out  1  high with the final output beat of the frame
busy  out  1  frame in progress
done  out  1  one-cycle pulse after the final beat handshake
cfg_err  out  1  one-cycle pulse when start is rejected

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: s_ready=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0, cfg_err=0; FSM=IDLE; all counters=0.
- Reset asserted mid-frame aborts the frame immediately. No done pulse; partial output is discarded.
- Config (in_height, in_width, scale, mode) is latched on an accepted start. Changes during busy are ignored.
- Start in IDLE with any of the following pulses cfg_err the next cycle and stays IDLE: scale=0, scale>MAX_SCALE, in_width=0, in_width>MAX_IN_WIDTH, in_height=0, mode>=2.
- Start while busy is ignored.
- FSM states:
  - IDLE: valid start moves to LOAD and sets busy=1.
  - LOAD: s_ready=1. Each s_valid&&s_ready handshake writes line_buf[col] and increments col. After in_width handshakes, go to EMIT; s_ready drops the cycle after the last handshake.
  - EMIT: s_ready=0. Counters sub_row (0..scale-1), out_col (0..in_width-1) and sub_col (0..scale-1) advance only on an m_valid&&m_ready handshake.
    - Nearest mode: m_data = line_buf[out_col].
    - Zero-insert mode: m_data = line_buf[out_col] when sub_row==0 and sub_col==0, else 0.
    - After the last beat of the last sub_row: if more input rows remain, go to LOAD; else go to DONE.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- No division or multiplication in the datapath; all indexing uses the nested counters.
- Output is registered: m_valid rises the cycle after the FSM enters EMIT. First output of each row therefore appears 2 cycles after the last input handshake of that row.
- With m_ready held high, one beat per cycle. EMIT lasts in_width*scale*scale beats per input row.
- Backpressure: while m_valid && !m_ready, m_data and m_last hold stable and counters hold.
- m_last=1 only on the beat where the final row, final sub_row, final out_col and final sub_col all coincide.
- LOAD and EMIT never overlap: no input is accepted while any row is being emitted.
- Total output beats per frame = in_height * in_width * scale^2.
- scale=1: the output is an exact pass-through of the input in both modes.
- Reserved modes never reach EMIT.

Test Plan:
- 2x2 input [1,2,3,4], scale=2, mode=0, m_ready=1 -> 16 beats: 1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4. m_last on beat 16; done pulses once.
- Same input, mode=1 -> 1,0,2,0,0,0,0,0,3,0,4,0,0,0,0,0.
- 1x3 input [7,8,9], scale=3, mode=0, m_ready toggling 1,0 each cycle -> 27 beats of 7x3,8x3,9x3 repeated 3 times. m_data is stable during every stall; no beat is lost or duplicated.
- start with scale=5 (MAX_SCALE=4) -> cfg_err pulses one cycle, busy stays 0, s_ready stays 0. Then start with in_width=33 -> cfg_err again.
- 4x32 input ramp 0..127, scale=1, mode=1 -> output identical to input (128 beats). m_last on beat 128; s_ready is low throughout each EMIT.
- Start a 2x2 scale=2 frame, assert rst after the 5th output beat -> all outputs return to reset values asynchronously. A fresh frame afterwards produces the full correct 16-beat sequence.
